spell_mem_master: RTL



---
 rtl/spell_bus_pkg.sv | 19 +
 rtl/spell_req_buf.sv | 57 +++++
 rtl/spell_mem_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spell_bus_pkg.sv
// Shared types and defaults for the Spell data/IO bus initiator.
package spell_bus_pkg;

    localparam int unsigned DEF_TIMEOUT      = 15;
    localparam logic [7:0]  DEF_TIMEOUT_DATA = 8'hFF;

    // Bus initiator states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    // CPU load/store request payload
    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } spell_req_t;

endpackage

// File: rtl/spell_req_buf.sv
// One-entry valid/ready holding register with bypass.
// When empty, an accepted request is presented combinationally on the output
// and only stored if the consumer does not take it in the same cycle.
module spell_req_buf
    import spell_bus_pkg::*;
#(
    parameter type T = spell_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    input  T     in_data_i,
    output logic in_ready_o,
    output logic out_valid_c_o,
    output T     out_data_c_o,
    input  logic out_take_i
);

    logic valid_q, valid_d;
    logic ready_q;
    T     data_q, data_d;
    logic in_fire;

    assign in_fire = in_valid_i & ready_q;

    // Holding-register update and bypass output selection
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q) begin
            if (out_take_i) begin
                valid_d = 1'b0;
            end
        end else if (in_fire && !out_take_i) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end
        out_valid_c_o = valid_q | in_fire;
        out_data_c_o  = valid_q ? data_q : in_data_i;
    end

    // State register; ready is low during reset and tracks emptiness after
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ready_q <= !valid_d;
        end
    end

    assign in_ready_o = ready_q;

endmodule

// File: rtl/spell_mem_master.sv
// Spell bus initiator: one transaction at a time, select held until
// data_ready, guaranteed select-low gap before the next launch.
module spell_mem_master
    import spell_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter logic [7:0]  TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       select,
    output logic [7:0] addr,
    output logic       write,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic       data_ready
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          select_q, select_d;
    logic [7:0]    addr_q, addr_d;
    logic          write_q, write_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    spell_req_t    in_req;
    spell_req_t    buf_req;
    logic          buf_avail;
    logic          take;

    assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata};

    spell_req_buf #(
        .T (spell_req_t)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (req_valid),
        .in_data_i     (in_req),
        .in_ready_o    (req_ready),
        .out_valid_c_o (buf_avail),
        .out_data_c_o  (buf_req),
        .out_take_i    (take)
    );

    // Saturating counter increment
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // Next-state and bus/response output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        select_d      = select_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        take          = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_avail) begin
                    take = 1'b1;
                end
            end
            ACCESS: begin
                if (data_ready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = write_q ? 8'h00 : data_in;
                    select_d      = 1'b0;
                    write_d       = 1'b0;
                    cnt_d         = '0;
                    state_d       = GAP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = TIMEOUT_DATA;
                    select_d      = 1'b0;
                    write_d       = 1'b0;
                    cnt_d         = '0;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                // Exit once the responder has dropped data_ready, or give up
                if (!data_ready || cnt_q == CNT_LAST) begin
                    if (buf_avail) begin
                        take = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            select_d = 1'b1;
            addr_d   = buf_req.addr;
            write_d  = buf_req.write;
            wdata_d  = buf_req.wdata;
            cnt_d    = '0;
            state_d  = ACCESS;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            select_q      <= 1'b0;
            addr_q        <= 8'h00;
            write_q       <= 1'b0;
            wdata_q       <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            select_q      <= select_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign select      = select_q;
    assign addr        = addr_q;
    assign write       = write_q;
    assign data_out    = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
